// File: rtl/regfile_pkg.sv
// Shared encodings for the windowed register file access controller:
// request opcodes, trap codes, controller states and window-count defaults.
package regfile_pkg;

    localparam int NWINDOWS_DEF = 3;

    typedef enum logic [1:0] {
        OP_READ    = 2'b00,
        OP_WRITE   = 2'b01,
        OP_SAVE    = 2'b10,
        OP_RESTORE = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        TRAP_NONE      = 2'b00,
        TRAP_OVERFLOW  = 2'b01,
        TRAP_UNDERFLOW = 2'b10
    } trap_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RCAP,
        ST_WSETUP,
        ST_WSTROBE,
        ST_WHOLD,
        ST_RESP
    } state_e;

    // Bits needed to hold a window index 0..n-1 (at least one).
    function automatic int cwp_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// Core-side request/response channel of the register file access controller.
// The core drives through master; the controller sits on slave.
interface regfile_access_ctrl_if
    import regfile_pkg::*;
#(
    parameter int NWINDOWS = NWINDOWS_DEF
) ();

    logic                req_valid;
    logic                req_ready;
    op_e                 req_op;
    logic [4:0]          req_rs1;
    logic [4:0]          req_rs2;
    logic [4:0]          req_rd;
    logic [31:0]         req_wdata;
    logic [NWINDOWS-1:0] wim_in;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [31:0]         rsp_a;
    logic [31:0]         rsp_b;
    trap_e               rsp_trap;

    modport master (
        output req_valid, req_op, req_rs1, req_rs2, req_rd, req_wdata, wim_in, rsp_ready,
        input  req_ready, rsp_valid, rsp_a, rsp_b, rsp_trap
    );

    modport slave (
        input  req_valid, req_op, req_rs1, req_rs2, req_rd, req_wdata, wim_in, rsp_ready,
        output req_ready, rsp_valid, rsp_a, rsp_b, rsp_trap
    );

endinterface

// File: rtl/cwp_unit.sv
// Current-window-pointer register with modulo-NWINDOWS SAVE/RESTORE stepping
// and window-invalid-mask trap detection.
module cwp_unit
    import regfile_pkg::*;
#(
    parameter  int NWINDOWS = NWINDOWS_DEF,
    localparam int CW       = cwp_bits(NWINDOWS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                update,
    input  op_e                 op,
    input  logic [NWINDOWS-1:0] wim,
    output logic [CW-1:0]       cwp,
    output trap_e               trap
);

    localparam logic [CW-1:0] LAST = CW'(NWINDOWS - 1);

    logic [CW-1:0] dec_cwp;
    logic [CW-1:0] inc_cwp;
    logic [CW-1:0] next_cwp;

    // A trapped SAVE/RESTORE leaves the window where it was.
    always_comb begin
        dec_cwp  = (cwp == '0)   ? LAST : cwp - CW'(1);
        inc_cwp  = (cwp == LAST) ? '0   : cwp + CW'(1);
        next_cwp = cwp;
        trap     = TRAP_NONE;
        case (op)
            OP_SAVE: begin
                if (wim[dec_cwp]) trap = TRAP_OVERFLOW;
                else              next_cwp = dec_cwp;
            end
            OP_RESTORE: begin
                if (wim[inc_cwp]) trap = TRAP_UNDERFLOW;
                else              next_cwp = inc_cwp;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         cwp <= '0;
        else if (update) cwp <= next_cwp;
    end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Initiator for a windowed register file: serves core READ/WRITE/SAVE/RESTORE
// requests and sequences the file's edge-triggered rd_wr strobe with setup/hold.
module regfile_access_ctrl
    import regfile_pkg::*;
#(
    parameter int NWINDOWS = NWINDOWS_DEF,
    parameter int CWP_W    = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_access_ctrl_if.slave bus,
    output logic [CWP_W-1:0]     cwp_out,
    output logic [4:0]           r1_sel,
    output logic [4:0]           r2_sel,
    output logic [4:0]           rd_sel,
    output logic [31:0]          rd_in,
    output logic                 rd_wr,
    input  logic [31:0]          r1_in,
    input  logic [31:0]          r2_in
);

    localparam int CW = cwp_bits(NWINDOWS);

    state_e              state;
    op_e                 op_q;
    logic [NWINDOWS-1:0] wim_q;
    logic                req_ready_q;
    logic                rsp_valid_q;
    logic [31:0]         rsp_a_q;
    logic [31:0]         rsp_b_q;
    trap_e               rsp_trap_q;
    logic [CW-1:0]       cwp;
    trap_e               cwp_trap;

    // The window moves on the same edge the old-window operands are captured.
    cwp_unit #(.NWINDOWS(NWINDOWS)) u_cwp (
        .clk    (clk),
        .rst    (rst),
        .update (state == ST_RCAP),
        .op     (op_q),
        .wim    (wim_q),
        .cwp    (cwp),
        .trap   (cwp_trap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            op_q        <= OP_READ;
            wim_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_a_q     <= '0;
            rsp_b_q     <= '0;
            rsp_trap_q  <= TRAP_NONE;
            r1_sel      <= '0;
            r2_sel      <= '0;
            rd_sel      <= '0;
            rd_in       <= '0;
            rd_wr       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r1_sel      <= bus.req_rs1;
                        r2_sel      <= bus.req_rs2;
                        rd_sel      <= bus.req_rd;
                        rd_in       <= bus.req_wdata;
                        op_q        <= bus.req_op;
                        wim_q       <= bus.wim_in;
                        req_ready_q <= 1'b0;
                        if (bus.req_op == OP_WRITE) begin
                            rsp_trap_q <= TRAP_NONE;
                            // g0 is hardwired; skip the strobe entirely.
                            if (bus.req_rd != 5'd0) begin
                                state <= ST_WSETUP;
                            end else begin
                                state       <= ST_RESP;
                                rsp_valid_q <= 1'b1;
                            end
                        end else begin
                            state <= ST_RCAP;
                        end
                    end
                end
                ST_RCAP: begin
                    rsp_a_q     <= r1_in;
                    rsp_b_q     <= r2_in;
                    rsp_trap_q  <= cwp_trap;
                    rsp_valid_q <= 1'b1;
                    state       <= ST_RESP;
                end
                ST_WSETUP: begin
                    rd_wr <= 1'b1;
                    state <= ST_WSTROBE;
                end
                ST_WSTROBE: begin
                    rd_wr <= 1'b0;
                    state <= ST_WHOLD;
                end
                ST_WHOLD: begin
                    rsp_valid_q <= 1'b1;
                    state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_a     = rsp_a_q;
    assign bus.rsp_b     = rsp_b_q;
    assign bus.rsp_trap  = rsp_trap_q;
    assign cwp_out       = CWP_W'(cwp);

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Self-checking bench for regfile_access_ctrl: directed vector table, stall and
// reset-during-strobe sequences, then random traffic against a window model.
module tb_regfile_access_ctrl;
    import regfile_pkg::*;

    localparam int NW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_access_ctrl_if #(.NWINDOWS(NW)) bus ();

    logic [4:0]  cwp_out;
    logic [4:0]  r1_sel, r2_sel, rd_sel;
    logic [31:0] rd_in, r1_in, r2_in;
    logic        rd_wr;

    regfile_access_ctrl #(.NWINDOWS(NW), .CWP_W(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .cwp_out (cwp_out),
        .r1_sel  (r1_sel),
        .r2_sel  (r2_sel),
        .rd_sel  (rd_sel),
        .rd_in   (rd_in),
        .rd_wr   (rd_wr),
        .r1_in   (r1_in),
        .r2_in   (r2_in)
    );

    int checks = 0;
    int errors = 0;
    int strobes = 0;

    // Simple windowed register file: independent windows, g0 reads zero.
    logic [31:0] file_mem [NW][32] = '{default: '0};
    int          file_w;
    assign file_w = int'(cwp_out) % NW;
    assign r1_in  = (r1_sel == 5'd0) ? 32'd0 : file_mem[file_w][r1_sel];
    assign r2_in  = (r2_sel == 5'd0) ? 32'd0 : file_mem[file_w][r2_sel];

    always @(posedge rd_wr) begin
        strobes = strobes + 1;
        if (rd_sel != 5'd0) file_mem[file_w][rd_sel] = rd_in;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Strobe-safety monitor: write address/data/window frozen around the pulse.
    logic        mon_en = 1'b0;
    logic        prev_wr = 1'b0;
    logic [4:0]  prev_sel = '0, prev_cwp = '0;
    logic [31:0] prev_in = '0;
    always @(negedge clk) begin
        if (mon_en && (rd_wr || prev_wr)) begin
            chk("strobe_sel_stable", {27'd0, rd_sel}, {27'd0, prev_sel});
            chk("strobe_data_stable", rd_in, prev_in);
            chk("strobe_cwp_stable", {27'd0, cwp_out}, {27'd0, prev_cwp});
            chk("strobe_one_cycle", 32'(rd_wr && prev_wr), 32'd0);
        end
        prev_wr  = rd_wr;
        prev_sel = rd_sel;
        prev_in  = rd_in;
        prev_cwp = cwp_out;
    end

    // Reference model: plain per-window arrays and modulo window arithmetic.
    logic [31:0] ref_mem [NW][32] = '{default: '0};
    int          ref_cwp = 0;
    logic [31:0] last_a = '0, last_b = '0;

    task automatic model_step(input op_e op, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic [31:0] wd, input logic [2:0] wim,
                              output logic [31:0] ea, output logic [31:0] eb,
                              output logic [1:0] et, output int ecwp, output int elat,
                              output int estr);
        int nw;
        et = 2'b00;
        if (op == OP_WRITE) begin
            ea   = last_a;
            eb   = last_b;
            estr = (rd != 0) ? 1 : 0;
            elat = (rd != 0) ? 4 : 1;
            if (rd != 0) ref_mem[ref_cwp][rd] = wd;
        end else begin
            ea   = (rs1 == 0) ? 32'd0 : ref_mem[ref_cwp][rs1];
            eb   = (rs2 == 0) ? 32'd0 : ref_mem[ref_cwp][rs2];
            estr = 0;
            elat = 2;
            if (op == OP_SAVE) begin
                nw = (ref_cwp + NW - 1) % NW;
                if (wim[nw]) et = 2'b01; else ref_cwp = nw;
            end else if (op == OP_RESTORE) begin
                nw = (ref_cwp + 1) % NW;
                if (wim[nw]) et = 2'b10; else ref_cwp = nw;
            end
        end
        last_a = ea;
        last_b = eb;
        ecwp   = ref_cwp;
    endtask

    task automatic drive_req(input op_e op, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic [31:0] wd, input logic [2:0] wim);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_rs1   = rs1;
        bus.req_rs2   = rs2;
        bus.req_rd    = rd;
        bus.req_wdata = wd;
        bus.wim_in    = wim;
    endtask

    // One full transaction; latency counts edges from accept to rsp_valid.
    task automatic run_check(input string tag, input op_e op, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] wd,
                             input logic [2:0] wim, input int hold,
                             input logic [31:0] ea, input logic [31:0] eb, input logic [1:0] et,
                             input int ecwp, input int elat, input int estr);
        int s0, lat;
        @(negedge clk);
        chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
        drive_req(op, rs1, rs2, rd, wd, wim);
        s0 = strobes;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!bus.rsp_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.rsp_valid) $display("FAIL %s.timeout: rsp_valid not seen after %0d edges", tag, lat);
        repeat (hold) @(negedge clk);
        chk({tag, ".latency"}, 32'(lat), 32'(elat));
        chk({tag, ".rsp_a"}, bus.rsp_a, ea);
        chk({tag, ".rsp_b"}, bus.rsp_b, eb);
        chk({tag, ".rsp_trap"}, 32'(bus.rsp_trap), 32'(et));
        chk({tag, ".cwp_out"}, 32'(cwp_out), 32'(ecwp));
        chk({tag, ".strobes"}, 32'(strobes - s0), 32'(estr));
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk({tag, ".rsp_drop"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    task automatic model_and_run(input string tag, input op_e op, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic [31:0] wd, input logic [2:0] wim, input int hold);
        logic [31:0] ea, eb;
        logic [1:0]  et;
        int          ec, el, es;
        model_step(op, rs1, rs2, rd, wd, wim, ea, eb, et, ec, el, es);
        run_check(tag, op, rs1, rs2, rd, wd, wim, hold, ea, eb, et, ec, el, es);
    endtask

    typedef struct {
        op_e         op;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] wd;
        logic [2:0]  wim;
        logic [31:0] ea, eb;
        logic [1:0]  et;
        int          ecwp, elat, estr;
    } vec_t;

    vec_t tbl [15];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ea, eb, hold_a;
        logic [1:0]  et;
        int          ec, el, es, s0, n;

        tbl[0]  = '{OP_WRITE,   5'd0, 5'd0, 5'd9, 32'hDEADBEEF, 3'b000, 32'h0,        32'h0,        2'b00, 0, 4, 1};
        tbl[1]  = '{OP_READ,    5'd9, 5'd0, 5'd0, 32'h0,        3'b000, 32'hDEADBEEF, 32'h0,        2'b00, 0, 2, 0};
        tbl[2]  = '{OP_WRITE,   5'd0, 5'd0, 5'd0, 32'h1234,     3'b000, 32'hDEADBEEF, 32'h0,        2'b00, 0, 1, 0};
        tbl[3]  = '{OP_READ,    5'd0, 5'd9, 5'd0, 32'h0,        3'b000, 32'h0,        32'hDEADBEEF, 2'b00, 0, 2, 0};
        tbl[4]  = '{OP_SAVE,    5'd9, 5'd9, 5'd0, 32'h0,        3'b000, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 2, 2, 0};
        tbl[5]  = '{OP_WRITE,   5'd0, 5'd0, 5'd5, 32'hA5A50001, 3'b000, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 2, 4, 1};
        tbl[6]  = '{OP_READ,    5'd5, 5'd9, 5'd0, 32'h0,        3'b000, 32'hA5A50001, 32'h0,        2'b00, 2, 2, 0};
        tbl[7]  = '{OP_RESTORE, 5'd5, 5'd0, 5'd0, 32'h0,        3'b000, 32'hA5A50001, 32'h0,        2'b00, 0, 2, 0};
        tbl[8]  = '{OP_READ,    5'd5, 5'd9, 5'd0, 32'h0,        3'b000, 32'h0,        32'hDEADBEEF, 2'b00, 0, 2, 0};
        tbl[9]  = '{OP_RESTORE, 5'd9, 5'd5, 5'd0, 32'h0,        3'b000, 32'hDEADBEEF, 32'h0,        2'b00, 1, 2, 0};
        tbl[10] = '{OP_RESTORE, 5'd0, 5'd0, 5'd0, 32'h0,        3'b000, 32'h0,        32'h0,        2'b00, 2, 2, 0};
        tbl[11] = '{OP_RESTORE, 5'd0, 5'd0, 5'd0, 32'h0,        3'b000, 32'h0,        32'h0,        2'b00, 0, 2, 0};
        tbl[12] = '{OP_SAVE,    5'd9, 5'd0, 5'd0, 32'h0,        3'b100, 32'hDEADBEEF, 32'h0,        2'b01, 0, 2, 0};
        tbl[13] = '{OP_RESTORE, 5'd0, 5'd9, 5'd0, 32'h0,        3'b010, 32'h0,        32'hDEADBEEF, 2'b10, 0, 2, 0};
        tbl[14] = '{OP_WRITE,   5'd0, 5'd0, 5'd3, 32'h0BADF00D, 3'b111, 32'h0,        32'hDEADBEEF, 2'b00, 0, 4, 1};

        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        drive_req(OP_READ, 5'd0, 5'd0, 5'd0, 32'd0, 3'b000);
        bus.req_valid = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset.rd_wr", 32'(rd_wr), 32'd0);
        chk("reset.cwp_out", 32'(cwp_out), 32'd0);
        chk("reset.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset.req_ready", 32'(bus.req_ready), 32'd1);
        chk("reset.rsp_a", bus.rsp_a, 32'd0);
        chk("reset.rsp_trap", 32'(bus.rsp_trap), 32'd0);
        chk("reset.sels", {17'd0, r1_sel, r2_sel, rd_sel}, 32'd0);
        chk("reset.rd_in", rd_in, 32'd0);
        mon_en = 1'b1;

        for (int i = 0; i < 15; i++) begin
            model_step(tbl[i].op, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].wd, tbl[i].wim,
                       ea, eb, et, ec, el, es);
            run_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].rs1, tbl[i].rs2, tbl[i].rd,
                      tbl[i].wd, tbl[i].wim, 0, tbl[i].ea, tbl[i].eb, tbl[i].et,
                      tbl[i].ecwp, tbl[i].elat, tbl[i].estr);
        end

        // Response back-pressure: a competing request must not be taken.
        model_step(OP_READ, 5'd9, 5'd3, 5'd2, 32'd0, 3'b000, ea, eb, et, ec, el, es);
        @(negedge clk);
        drive_req(OP_READ, 5'd9, 5'd3, 5'd2, 32'd0, 3'b000);
        s0 = strobes;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        drive_req(OP_WRITE, 5'd0, 5'd0, 5'd4, 32'h00000BAD, 3'b000);
        hold_a = bus.rsp_a;
        chk("stall.rsp_a", hold_a, ea);
        for (int i = 0; i < 5; i++) begin
            chk("stall.rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("stall.rsp_a_hold", bus.rsp_a, hold_a);
            chk("stall.req_ready", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk("stall.rsp_drop", 32'(bus.rsp_valid), 32'd0);
        chk("stall.not_accepted_sel", 32'(rd_sel), 32'd2);
        chk("stall.not_accepted_strobe", 32'(strobes - s0), 32'd0);

        // Reset while the write strobe is high, then a clean write/read.
        model_and_run("rst.save", OP_SAVE, 5'd0, 5'd0, 5'd0, 32'd0, 3'b000, 0);
        @(negedge clk);
        drive_req(OP_WRITE, 5'd0, 5'd0, 5'd7, 32'h00000077, 3'b000);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rd_wr && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("rst.strobe_seen", 32'(rd_wr), 32'd1);
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst.rd_wr", 32'(rd_wr), 32'd0);
        chk("rst.cwp_out", 32'(cwp_out), 32'd0);
        chk("rst.req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst.rd_sel", 32'(rd_sel), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
        ref_mem[2][7] = 32'h00000077;
        ref_cwp = 0;
        last_a = '0;
        last_b = '0;
        model_and_run("rst.write", OP_WRITE, 5'd0, 5'd0, 5'd7, 32'h12345678, 3'b000, 0);
        model_and_run("rst.read", OP_READ, 5'd7, 5'd9, 5'd0, 32'd0, 3'b000, 1);

        for (int i = 0; i < 80; i++) begin
            op_e         op;
            logic [2:0]  wim;
            op  = op_e'($urandom_range(0, 3));
            wim = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            model_and_run($sformatf("rnd%0d", i), op, 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, wim,
                          int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
